// File: rtl/sram_arbiter_if.sv
// Bus bundle between the memory manager / host side and the SRAM arbiter,
// carrying the video, CPU, host boot and SRAM pin signals.
interface sram_arbiter_if;
   // video fetch port
   logic        vid_req;
   logic [20:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_rdata;

   // Z80 memory port
   logic        cpu_req;
   logic        cpu_we;
   logic [20:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   // host boot loader handshake
   logic [31:0] host_bootdata;
   logic        host_bootdata_req;
   logic        host_bootdata_ack;
   logic        host_rom_initialised;

   // SRAM pins and debug owner
   logic [20:0] sram_addr;
   logic [7:0]  sram_dout;
   logic [7:0]  sram_din;
   logic        sram_data_oe;
   logic        sram_we_n;
   logic [1:0]  grant;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             host_bootdata, host_bootdata_req, sram_din,
      output vid_ack, vid_rdata, cpu_ack, cpu_rdata, host_bootdata_ack,
             host_rom_initialised, sram_addr, sram_dout, sram_data_oe,
             sram_we_n, grant
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             host_bootdata, host_bootdata_req, sram_din,
      input  vid_ack, vid_rdata, cpu_ack, cpu_rdata, host_bootdata_ack,
             host_rom_initialised, sram_addr, sram_dout, sram_data_oe,
             sram_we_n, grant
   );
endinterface

// File: rtl/sram_arbiter.sv
// Fixed-priority (video > cpu > host) arbiter for the shared 8-bit SRAM with a
// built-in loader that unpacks 32-bit host boot words into ROM byte writes.
module sram_arbiter #(
   parameter int          ACC_CYCLES = 2,
   parameter logic [20:0] ROM_BASE   = 21'h010000,
   parameter int          ROM_BYTES  = 49152
) (
   input logic           ck16,
   input logic           reset_n,
   sram_arbiter_if.slave bus
);
   localparam int            CW       = $clog2(ACC_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
   localparam logic [20:0]   ROM_END  = 21'(ROM_BYTES);

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_VID  = 2'd1;
   localparam logic [1:0] G_CPU  = 2'd2;
   localparam logic [1:0] G_HOST = 2'd3;

   typedef enum logic {A_IDLE, A_BUSY} arb_state_t;
   typedef enum logic [1:0] {L_WAIT, L_WRITE, L_ACK} ld_state_t;

   arb_state_t    arb_state_reg, arb_state_next;
   logic [CW-1:0] cnt_reg;
   logic [1:0]    grant_reg;
   logic          we_reg;
   logic [20:0]   addr_reg;
   logic [7:0]    dout_reg;
   logic          vid_ack_reg, cpu_ack_reg, host_ack_reg;
   logic [7:0]    vid_rdata_reg, cpu_rdata_reg;

   ld_state_t     ld_state_reg, ld_state_next;
   logic [31:0]   word_reg;
   logic [1:0]    k_reg;
   logic [20:0]   byte_ptr_reg;
   logic          rom_init_reg;
   logic          boot_ack_reg;

   logic          host_req;
   logic          vid_elig, cpu_elig, host_elig;
   logic [1:0]    win;
   logic          access_end;
   logic          host_done;
   logic [20:0]   byte_ptr_inc;
   logic          reach_end;
   logic [20:0]   host_addr;
   logic [7:0]    host_byte;

   // A requester is ignored in its own ack cycle so a one-cycle-late req drop
   // does not start a second access.
   assign host_req  = (ld_state_reg == L_WRITE);
   assign vid_elig  = bus.vid_req & ~vid_ack_reg;
   assign cpu_elig  = bus.cpu_req & ~cpu_ack_reg;
   assign host_elig = host_req & ~host_ack_reg;

   always_comb begin
      win = G_NONE;
      if (vid_elig)
         win = G_VID;
      else if (cpu_elig)
         win = G_CPU;
      else if (host_elig)
         win = G_HOST;
   end

   assign access_end   = (arb_state_reg == A_BUSY) && (cnt_reg == CNT_LAST);
   assign host_done    = access_end && (grant_reg == G_HOST);
   assign byte_ptr_inc = byte_ptr_reg + 21'd1;
   assign reach_end    = (byte_ptr_inc == ROM_END);
   assign host_addr    = ROM_BASE + byte_ptr_reg;
   assign host_byte    = word_reg[{k_reg, 3'b000} +: 8];

   // ---------------- arbiter FSM ----------------
   always_ff @(posedge ck16 or negedge reset_n) begin
      if (!reset_n)
         arb_state_reg <= A_IDLE;
      else
         arb_state_reg <= arb_state_next;
   end

   always_comb begin
      arb_state_next = arb_state_reg;
      unique case (arb_state_reg)
         A_IDLE: if (win != G_NONE) arb_state_next = A_BUSY;
         A_BUSY: if (cnt_reg == CNT_LAST) arb_state_next = A_IDLE;
         default: arb_state_next = A_IDLE;
      endcase
   end

   always_ff @(posedge ck16 or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg       <= '0;
         grant_reg     <= G_NONE;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         dout_reg      <= '0;
         vid_ack_reg   <= 1'b0;
         cpu_ack_reg   <= 1'b0;
         host_ack_reg  <= 1'b0;
         vid_rdata_reg <= '0;
         cpu_rdata_reg <= '0;
      end else begin
         vid_ack_reg  <= 1'b0;
         cpu_ack_reg  <= 1'b0;
         host_ack_reg <= 1'b0;
         if (arb_state_reg == A_IDLE) begin
            cnt_reg <= '0;
            if (win != G_NONE) begin
               grant_reg <= win;
               unique case (win)
                  G_VID: begin
                     addr_reg <= bus.vid_addr;
                     we_reg   <= 1'b0;
                  end
                  G_CPU: begin
                     addr_reg <= bus.cpu_addr;
                     we_reg   <= bus.cpu_we;
                     dout_reg <= bus.cpu_wdata;
                  end
                  default: begin
                     addr_reg <= host_addr;
                     we_reg   <= 1'b1;
                     dout_reg <= host_byte;
                  end
               endcase
            end
         end else if (access_end) begin
            cnt_reg   <= '0;
            grant_reg <= G_NONE;
            unique case (grant_reg)
               G_VID: begin
                  vid_ack_reg   <= 1'b1;
                  vid_rdata_reg <= bus.sram_din;
               end
               G_CPU: begin
                  cpu_ack_reg <= 1'b1;
                  if (!we_reg)
                     cpu_rdata_reg <= bus.sram_din;
               end
               G_HOST:  host_ack_reg <= 1'b1;
               default: ;
            endcase
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // Write strobe is held off for the first busy cycle to give address setup.
   always_comb begin
      bus.sram_data_oe = 1'b0;
      bus.sram_we_n    = 1'b1;
      if (arb_state_reg == A_BUSY && we_reg) begin
         bus.sram_data_oe = 1'b1;
         bus.sram_we_n    = (cnt_reg == '0);
      end
   end

   assign bus.sram_addr = addr_reg;
   assign bus.sram_dout = dout_reg;
   assign bus.grant     = grant_reg;
   assign bus.vid_ack   = vid_ack_reg;
   assign bus.vid_rdata = vid_rdata_reg;
   assign bus.cpu_ack   = cpu_ack_reg;
   assign bus.cpu_rdata = cpu_rdata_reg;

   // ---------------- loader FSM ----------------
   always_ff @(posedge ck16 or negedge reset_n) begin
      if (!reset_n)
         ld_state_reg <= L_WAIT;
      else
         ld_state_reg <= ld_state_next;
   end

   always_comb begin
      ld_state_next = ld_state_reg;
      unique case (ld_state_reg)
         L_WAIT:
            if (bus.host_bootdata_req)
               ld_state_next = rom_init_reg ? L_ACK : L_WRITE;
         L_WRITE:
            if (host_done && (k_reg == 2'd3 || reach_end))
               ld_state_next = L_ACK;
         L_ACK:
            if (!bus.host_bootdata_req)
               ld_state_next = L_WAIT;
         default: ld_state_next = L_WAIT;
      endcase
   end

   // Once the image is complete the pointer freezes and no more writes issue.
   always_ff @(posedge ck16 or negedge reset_n) begin
      if (!reset_n) begin
         word_reg     <= '0;
         k_reg        <= '0;
         byte_ptr_reg <= '0;
         rom_init_reg <= 1'b0;
         boot_ack_reg <= 1'b0;
      end else begin
         boot_ack_reg <= (ld_state_next == L_ACK);
         if (ld_state_reg == L_WAIT && bus.host_bootdata_req && !rom_init_reg) begin
            word_reg <= bus.host_bootdata;
            k_reg    <= '0;
         end
         if (host_done) begin
            byte_ptr_reg <= byte_ptr_inc;
            k_reg        <= k_reg + 2'd1;
            if (reach_end)
               rom_init_reg <= 1'b1;
         end
      end
   end

   assign bus.host_bootdata_ack    = boot_ack_reg;
   assign bus.host_rom_initialised = rom_init_reg;
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external 8-bit SRAM between three requesters: video fetch, Z80 CPU memory port and the host ROM loader.
- The loader is built in. It unpacks 32-bit host boot words into byte writes at a fixed ROM region and reports when the ROM image is complete.
- The block sits between the memory manager (CPU/video sides) and the SRAM pins, and owns the SRAM address, data and write-enable lines.

Parameters:
ACC_CYCLES, 2, SRAM cycles per access (>=2).
ROM_BASE, 21'h010000, SRAM byte address of the first loaded ROM byte.
ROM_BYTES, 49152, bytes to load before host_rom_initialised rises (OS+BASIC+AMSDOS).

Ports:
ck16  in  1  system clock, 16 MHz
reset_n  in  1  asynchronous active-low reset
vid_req  in  1  video read request (level)
vid_addr  in  21  video byte address
vid_ack  out  1  one-cycle pulse, vid_rdata valid
vid_rdata  out  8  video read data, held until next vid_ack
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  21  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle pulse, access done
cpu_rdata  out  8  CPU read data, held until next cpu_ack
host_bootdata  in  32  boot word from host
host_bootdata_req  in  1  4-phase request
host_bootdata_ack  out  1  4-phase acknowledge
host_rom_initialised  out  1  ROM image loaded, sticky
sram_addr  out  21  SRAM address
sram_dout  out  8  SRAM write data
sram_din  in  8  SRAM read data
sram_data_oe  out  1  drive sram_dout onto bus
sram_we_n  out  1  SRAM write strobe
grant  out  2  current owner: 0 none, 1 video, 2 cpu, 3 host (debug)

Behaviour:
- Reset (async, any time, including mid-access):
  - States: arbiter IDLE, loader L_WAIT.
  - Outputs: grant=0, sram_we_n=1, sram_data_oe=0, sram_addr=0, sram_dout=0.
  - All acks 0, rdata regs 0, host_rom_initialised=0, byte pointer 0.
  - An interrupted write is abandoned, not retried.
- Arbiter FSM, IDLE -> BUSY -> IDLE:
  - IDLE: sample requests. Fixed priority video > cpu > host.
  - A requester whose ack is high in the current cycle is excluded from this cycle's arbitration, so holding req for one cycle after ack causes no duplicate access.
  - On a winner: latch address, we and data; set grant; go to BUSY with cnt=0.
  - BUSY lasts exactly ACC_CYCLES cycles (cnt 0..ACC_CYCLES-1). sram_addr holds the latched address throughout.
  - Write: sram_data_oe=1 for all BUSY cycles; sram_we_n=0 for cnt>=1; sram_we_n=1 at cnt=0 (address setup).
  - Read: sram_data_oe=0 and sram_we_n=1 throughout.
  - On the edge ending cnt=ACC_CYCLES-1: capture sram_din into the owner's rdata (reads only), pulse the owner's ack for 1 cycle, grant<=0, state<=IDLE.
  - Latency: a request sampled in IDLE at cycle t gives ack at cycle t+ACC_CYCLES+1. With the default, t+3.
  - No preemption. Worst-case video latency is 2*ACC_CYCLES+1 cycles after an access has just started.
  - An access is back-to-back possible: a new grant may be made in the ack cycle.
- Loader FSM: L_WAIT, L_WRITE, L_ACK.
  - L_WAIT: when host_bootdata_req=1, latch the word, set byte index k=0, go to L_WRITE.
  - L_WRITE: raise the internal host request. Byte k = word[8k+7:8k], LSB first. Address = (ROM_BASE + byte_ptr) mod 2^21.
  - Each internal ack: byte_ptr+1, k+1. After byte 3 is acked, go to L_ACK.
  - When byte_ptr reaches ROM_BYTES, host_rom_initialised<=1 on the same edge. Remaining bytes of that word are not written.
  - L_ACK: host_bootdata_ack=1 until host_bootdata_req=0, then ack<=0 and go to L_WAIT.
  - Once host_rom_initialised=1, further words are acked via L_ACK with no SRAM writes.
  - host_bootdata changing while req=1 is ignored (word already latched).
- cpu_we, cpu_addr and cpu_wdata are sampled only at grant; they may change afterwards.

Test Plan:
1. Reset, then cpu_req=1, cpu_we=0, cpu_addr=21'h00123, SRAM model returns 8'h5A. Require: cpu_ack exactly 3 cycles after the first sampled request, cpu_rdata=8'h5A, sram_we_n stays 1.
2. CPU write 8'hC3 to 21'h04000. Require: sram_data_oe=1 for 2 cycles, sram_we_n=1 then 0, sram_dout=8'hC3, SRAM model holds 8'hC3 at 21'h04000.
3. vid_req and cpu_req rise in the same cycle. Require: video served first (grant=1, vid_ack at +3); CPU granted in the vid_ack cycle, cpu_ack at +6. No duplicate video access while vid_req drops one cycle after its ack.
4. Host word 32'h44332211 (4-phase). Require: SRAM bytes 11,22,33,44 at ROM_BASE..ROM_BASE+3 in that order. host_bootdata_ack high after the 4th write, low the cycle after req falls.
5. Load with ROM_BYTES=8 (override): two words complete. Require: host_rom_initialised rises on the 8th byte write edge; a third word is acked with zero SRAM writes.
6. Assert reset_n=0 during cnt=1 of a CPU write. Require: immediately sram_we_n=1, sram_data_oe=0, grant=0, cpu_ack=0. After release, a fresh request completes normally in 3 cycles.
